// File: rtl/sd_block_arbiter_pkg.sv
// Shared types and constants for the two-requester SD block arbiter.
package sd_arb_pkg;

  // Arbiter FSM states; the encoding is exported on the debug port.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARB    = 3'd1,
    ISSUE  = 3'd2,
    ACTIVE = 3'd3,
    DRAIN  = 3'd4,
    FAIL   = 3'd5
  } state_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  localparam int DEF_BYTES_PER_BLOCK = 512;

endpackage

// File: rtl/sd_block_arbiter_rr.sv
// Two-way round-robin picker: combinational choice, registered memory of
// the last winner so that a tie goes to the requester not served last.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] pick
);

  // Index of the last winner; 1 after reset so requester 0 wins the first tie.
  logic last_grant;

  // Choose a one-hot winner from the current request vector.
  always_comb begin
    pick = 2'b00;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last_grant ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
  end

  // Remember the winner whenever the owner commits to a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (update && (pick != 2'b00)) begin
      last_grant <= pick[1];
    end
  end

endmodule

// File: rtl/sd_block_arbiter.sv
// Shares one single-block SD controller between two block requesters with
// round-robin arbitration, a transfer watchdog and a byte-count check.
//
// Handshake: a requester raises req[i] (with op/addr stable) and holds it
// until it sees a one-cycle done[i] or err[i]; op/addr are sampled in the
// ARB cycle. Toward the controller, sd_execute is held high until sd_busy
// is observed high, which is taken as acceptance of the command.
module sd_block_arbiter
  import sd_arb_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int BYTES_PER_BLOCK = DEF_BYTES_PER_BLOCK,
  parameter int TIMEOUT_CYCLES  = 1048576
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [7:0]        wdata0,
  input  logic [7:0]        wdata1,
  output logic [1:0]        grant,
  output logic [1:0]        byte_stb,
  output logic [7:0]        rdata,
  output logic [1:0]        done,
  output logic [1:0]        err,
  output logic              sd_execute,
  output logic              sd_op_code,
  output logic [ADDR_W-1:0] sd_block_address,
  output logic [7:0]        sd_outgoing_byte,
  input  logic [7:0]        sd_incoming_byte,
  input  logic              sd_finished_byte,
  input  logic              sd_finished_block,
  input  logic              sd_busy,
  output state_t            state_dbg
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int CW = $clog2(BYTES_PER_BLOCK + 2);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(BYTES_PER_BLOCK);
  localparam logic [CW-1:0] CNT_SAT  = CW'(BYTES_PER_BLOCK + 1);

  state_t          state;
  state_t          state_nxt;
  logic [1:0]      pick;
  logic            owner;
  logic [1:0]      owner_oh;
  logic [TW-1:0]   timer;
  logic [CW-1:0]   byte_cnt;
  logic [CW-1:0]   cnt_inc;
  logic            ok;
  logic            byte_hit;

  assign owner_oh  = owner ? 2'b10 : 2'b01;
  assign state_dbg = state;
  assign cnt_inc   = (byte_cnt == CNT_SAT) ? CNT_SAT : byte_cnt + 1'b1;
  assign byte_hit  = (state == ACTIVE) && sd_finished_byte;

  rr_arbiter2 u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .update (state == ARB),
    .pick   (pick)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode plus the state-derived controller/grant outputs.
  always_comb begin
    state_nxt        = state;
    grant            = 2'b00;
    sd_execute       = 1'b0;
    case (state)
      IDLE: begin
        if (!sd_busy && (req != 2'b00)) state_nxt = ARB;
      end
      ARB: begin
        state_nxt = (pick != 2'b00) ? ISSUE : IDLE;
      end
      ISSUE: begin
        grant      = owner_oh;
        sd_execute = 1'b1;
        if (sd_busy)              state_nxt = ACTIVE;
        else if (timer == T_LAST) state_nxt = FAIL;
      end
      ACTIVE: begin
        grant = owner_oh;
        if (sd_finished_block)     state_nxt = DRAIN;
        else if (timer == T_LAST)  state_nxt = FAIL;
      end
      DRAIN, FAIL: begin
        grant = owner_oh;
        if (!sd_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    sd_outgoing_byte = grant[1] ? wdata1 : (grant[0] ? wdata0 : 8'h00);
  end

  // Capture owner, op and address in ARB; they stay put until the next ARB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner            <= 1'b0;
      sd_op_code       <= OP_READ;
      sd_block_address <= '0;
    end else if ((state == ARB) && (pick != 2'b00)) begin
      owner            <= pick[1];
      sd_op_code       <= pick[1] ? op[1] : op[0];
      sd_block_address <= pick[1] ? addr1 : addr0;
    end
  end

  // Watchdog: zero through IDLE/ARB entry, counts from ARB, never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (state == IDLE) begin
      timer <= '0;
    end else if (((state == ARB) || (state == ISSUE) || (state == ACTIVE)) &&
                 (timer != T_LAST)) begin
      timer <= timer + 1'b1;
    end
  end

  // Byte counter and block verdict; a byte in the finishing cycle counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      ok       <= 1'b0;
    end else if (state == ARB) begin
      byte_cnt <= '0;
      ok       <= 1'b0;
    end else if (state == ACTIVE) begin
      if (sd_finished_byte) byte_cnt <= cnt_inc;
      if (sd_finished_block) begin
        ok <= ((sd_finished_byte ? cnt_inc : byte_cnt) == CNT_FULL);
      end
    end
  end

  // Read byte path: strobe and data registered together, ACTIVE only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_stb <= 2'b00;
      rdata    <= 8'h00;
    end else begin
      byte_stb <= byte_hit ? owner_oh : 2'b00;
      if (byte_hit) rdata <= sd_incoming_byte;
    end
  end

  // Completion pulses: verdict after DRAIN, or once on entry to FAIL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 2'b00;
      err  <= 2'b00;
    end else begin
      done <= 2'b00;
      err  <= 2'b00;
      if ((state == DRAIN) && !sd_busy) begin
        if (ok) done <= owner_oh;
        else    err  <= owner_oh;
      end else if ((state_nxt == FAIL) && (state != FAIL)) begin
        err <= owner_oh;
      end
    end
  end

endmodule

// File: tb/tb_sd_block_arbiter.sv
// Directed bench for sd_block_arbiter with a hand-driven controller model.
module tb_sd_block_arbiter;
  import sd_arb_pkg::*;

  localparam int ADDR_W  = 32;
  localparam int BPB     = 512;
  localparam int TIMEOUT = 1024;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]        req, op;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [7:0]        wdata0, wdata1;
  logic [1:0]        grant, byte_stb, done, err;
  logic [7:0]        rdata;
  logic              sd_execute, sd_op_code;
  logic [ADDR_W-1:0] sd_block_address;
  logic [7:0]        sd_outgoing_byte, sd_incoming_byte;
  logic              sd_finished_byte, sd_finished_block, sd_busy;
  state_t            state_dbg;

  sd_block_arbiter #(
    .ADDR_W          (ADDR_W),
    .BYTES_PER_BLOCK (BPB),
    .TIMEOUT_CYCLES  (TIMEOUT)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req               (req),
    .op                (op),
    .addr0             (addr0),
    .addr1             (addr1),
    .wdata0            (wdata0),
    .wdata1            (wdata1),
    .grant             (grant),
    .byte_stb          (byte_stb),
    .rdata             (rdata),
    .done              (done),
    .err               (err),
    .sd_execute        (sd_execute),
    .sd_op_code        (sd_op_code),
    .sd_block_address  (sd_block_address),
    .sd_outgoing_byte  (sd_outgoing_byte),
    .sd_incoming_byte  (sd_incoming_byte),
    .sd_finished_byte  (sd_finished_byte),
    .sd_finished_block (sd_finished_block),
    .sd_busy           (sd_busy),
    .state_dbg         (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int         tests = 0;
  int         fails = 0;
  int         stb_seen = 0;
  logic [1:0] exp_stb = 2'b01;
  logic [7:0] exp_q[$];
  logic [7:0] mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every byte strobe must match the next byte the controller model sent.
  always @(negedge clk) begin
    if (rst_n && (byte_stb != 2'b00)) begin
      stb_seen++;
      if (exp_q.size() == 0) begin
        check("byte_stb_unexpected", {62'd0, byte_stb}, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rdata", {56'd0, rdata}, {56'd0, mon_e});
        check("byte_stb_owner", {62'd0, byte_stb}, {62'd0, exp_stb});
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  req;
    logic [1:0]  op;
    logic [31:0] a0;
    logic [31:0] a1;
    int          nbytes;
    bit          merge;   // last byte arrives together with finished_block
    bit          hang;    // controller never finishes the block
    bit          keep;    // req stays asserted after completion
    logic [1:0]  exp_grant;
    logic        exp_op;
    logic [31:0] exp_addr;
    logic [1:0]  exp_done;
    logic [1:0]  exp_err;
  } vec_t;

  vec_t vecs[9];

  // ---------------- driver tasks ----------------
  task automatic wait_grant();
    int n = 0;
    while ((grant == 2'b00) && (n < 20)) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int  n;
    int  c;
    int  s0;
    string tag;
    tag = $sformatf("v%0d", idx);
    req = v.req; op = v.op; addr0 = v.a0; addr1 = v.a1;
    wait_grant();
    check({tag, "_grant"},   {62'd0, grant}, {62'd0, v.exp_grant});
    check({tag, "_addr"},    {32'd0, sd_block_address}, {32'd0, v.exp_addr});
    check({tag, "_op_code"}, {63'd0, sd_op_code}, {63'd0, v.exp_op});
    check({tag, "_execute"}, {63'd0, sd_execute}, 64'd1);
    exp_stb = v.exp_grant;
    sd_busy = 1'b1;
    @(negedge clk);
    check({tag, "_execute_drop"}, {63'd0, sd_execute}, 64'd0);
    if (v.hang) begin
      c = 2;
      while ((err == 2'b00) && (c < TIMEOUT + 8)) begin
        @(negedge clk);
        c++;
      end
      req = 2'b00;
      check({tag, "_timeout_cycle"}, c, TIMEOUT);
      check({tag, "_err"},  {62'd0, err},   {62'd0, v.exp_err});
      check({tag, "_done"}, {62'd0, done},  {62'd0, v.exp_done});
      check({tag, "_fail_grant"}, {62'd0, grant}, {62'd0, v.exp_grant});
      s0 = stb_seen;
      sd_finished_byte = 1'b1; sd_incoming_byte = 8'h77;
      @(negedge clk);
      sd_finished_byte = 1'b0; sd_finished_block = 1'b1;
      @(negedge clk);
      sd_finished_block = 1'b0;
      @(negedge clk);
      check({tag, "_late_stb"}, stb_seen - s0, 0);
      check({tag, "_err_once"}, {62'd0, err}, 64'd0);
      check({tag, "_grant_busy"}, {62'd0, grant}, {62'd0, v.exp_grant});
      sd_busy = 1'b0;
      repeat (2) @(negedge clk);
      check({tag, "_grant_release"}, {62'd0, grant}, 64'd0);
      check({tag, "_state_idle"}, {61'd0, state_dbg}, {61'd0, IDLE});
    end else begin
      s0 = stb_seen;
      for (int i = 0; i < v.nbytes; i++) begin
        sd_finished_byte = 1'b1;
        sd_incoming_byte = i[7:0];
        exp_q.push_back(i[7:0]);
        if (v.merge && (i == v.nbytes - 1)) sd_finished_block = 1'b1;
        if ((i % 128) == 5) begin
          wdata0 = 8'($urandom_range(1, 255));
          wdata1 = 8'($urandom_range(1, 255));
          #1;
          check({tag, "_outgoing"}, {56'd0, sd_outgoing_byte},
                {56'd0, (v.exp_grant[1] ? wdata1 : wdata0)});
        end
        @(negedge clk);
      end
      sd_finished_byte = 1'b0;
      if (!v.merge) begin
        sd_finished_block = 1'b1;
        @(negedge clk);
      end
      sd_finished_block = 1'b0;
      repeat (3) @(negedge clk);
      check({tag, "_drain_grant"}, {62'd0, grant}, {62'd0, v.exp_grant});
      check({tag, "_drain_no_done"}, {60'd0, done, err}, 64'd0);
      check({tag, "_stb_count"}, stb_seen - s0, v.nbytes);
      sd_busy = 1'b0;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (((done | err) == 2'b00) && (n < 10));
      check({tag, "_done"}, {62'd0, done}, {62'd0, v.exp_done});
      check({tag, "_err"},  {62'd0, err},  {62'd0, v.exp_err});
      check({tag, "_grant_drop"}, {62'd0, grant}, 64'd0);
      if (!v.keep) req = 2'b00;
      @(negedge clk);
      check({tag, "_pulse_width"}, {60'd0, done, err}, 64'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int bad;
    vecs[0] = '{2'b01, 2'b00, 32'h10,   32'h20,  512, 0, 0, 0, 2'b01, 1'b0, 32'h10,   2'b01, 2'b00};
    vecs[1] = '{2'b11, 2'b10, 32'h100,  32'h200, 512, 0, 0, 1, 2'b10, 1'b1, 32'h200,  2'b10, 2'b00};
    vecs[2] = '{2'b11, 2'b10, 32'h100,  32'h200, 512, 1, 0, 1, 2'b01, 1'b0, 32'h100,  2'b01, 2'b00};
    vecs[3] = '{2'b11, 2'b10, 32'h100,  32'h200, 512, 0, 0, 0, 2'b10, 1'b1, 32'h200,  2'b10, 2'b00};
    vecs[4] = '{2'b10, 2'b10, 32'h0,    32'h3000,512, 0, 0, 0, 2'b10, 1'b1, 32'h3000, 2'b10, 2'b00};
    vecs[5] = '{2'b01, 2'b01, 32'h44,   32'h0,   511, 0, 0, 0, 2'b01, 1'b1, 32'h44,   2'b00, 2'b01};
    vecs[6] = '{2'b10, 2'b00, 32'h0,    32'h55,  513, 0, 0, 0, 2'b10, 1'b0, 32'h55,   2'b00, 2'b10};
    vecs[7] = '{2'b01, 2'b00, 32'h66,   32'h0,   0,   0, 1, 0, 2'b01, 1'b0, 32'h66,   2'b00, 2'b01};
    vecs[8] = '{2'b11, 2'b01, 32'h77,   32'h88,  512, 0, 0, 0, 2'b10, 1'b0, 32'h88,   2'b10, 2'b00};

    rst_n = 1'b0; req = 2'b00; op = 2'b00; addr0 = '0; addr1 = '0;
    wdata0 = 8'h5A; wdata1 = 8'hC3; sd_incoming_byte = 8'h00;
    sd_finished_byte = 1'b0; sd_finished_block = 1'b0; sd_busy = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_grant", {62'd0, grant}, 64'd0);
    check("reset_outgoing", {56'd0, sd_outgoing_byte}, 64'd0);
    check("reset_state", {61'd0, state_dbg}, {61'd0, IDLE});
    check("reset_pulses", {58'd0, byte_stb, done, err}, 64'd0);

    // Card init: busy held for 100 cycles with requester 0 waiting.
    req = 2'b01; op = 2'b00; addr0 = 32'h100;
    rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (sd_execute || (grant != 2'b00)) bad++;
    end
    check("init_no_execute", bad, 0);
    sd_busy = 1'b0;
    wait_grant();
    check("init_grant", {62'd0, grant}, 64'd1);
    check("init_execute", {63'd0, sd_execute}, 64'd1);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (!sd_execute) bad++;
    end
    check("execute_held", bad, 0);
    sd_busy = 1'b1;
    @(negedge clk);
    check("active_state", {61'd0, state_dbg}, {61'd0, ACTIVE});

    // Reset mid-ACTIVE with a byte strobe in flight.
    exp_stb = 2'b01;
    sd_finished_byte = 1'b1; sd_incoming_byte = 8'h3C; exp_q.push_back(8'h3C);
    @(negedge clk);
    sd_incoming_byte = 8'hA5; exp_q.push_back(8'hA5);
    @(negedge clk);
    check("pre_reset_stb", {62'd0, byte_stb}, 64'd1);
    rst_n = 1'b0;
    sd_finished_byte = 1'b0;
    #1;
    check("midreset_grant", {62'd0, grant}, 64'd0);
    check("midreset_stb", {62'd0, byte_stb}, 64'd0);
    check("midreset_rdata", {56'd0, rdata}, 64'd0);
    check("midreset_addr", {32'd0, sd_block_address}, 64'd0);
    check("midreset_misc", {59'd0, sd_execute, done, err}, 64'd0);
    exp_q.delete();
    req = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    sd_busy = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], i);
    end

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
